// File: rtl/arcino_pkg.sv
// Shared types and helpers for the arcino core register-file path.
package arcino_pkg;

   localparam int ADDR_WIDTH = 5;

   // Which writeback source owns the RF write port in a given cycle.
   typedef enum logic [1:0] {
      WB_SRC_NONE = 2'd0,
      WB_SRC_EX   = 2'd1,
      WB_SRC_LSU  = 2'd2
   } rf_wb_src_e;

   // RV32E has only 16 registers, so bit 4 of a register address is ignored.
   function automatic logic [ADDR_WIDTH-1:0] rf_addr_mask(input logic [ADDR_WIDTH-1:0] addr,
                                                          input logic rv32e);
      rf_addr_mask = rv32e ? {1'b0, addr[ADDR_WIDTH-2:0]} : addr;
   endfunction

endpackage

// File: rtl/arcino_rf_inflight_trk.sv
// Tracks register writes still in flight toward the RF and flags reads
// that would return stale data. S1 is the write currently on the RF port,
// S2 is the one the RF is sampling internally.
module arcino_rf_inflight_trk
   import arcino_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  s1_valid,
   input  logic [ADDR_WIDTH-1:0] s1_addr,
   input  logic [ADDR_WIDTH-1:0] raddr_a,
   input  logic [ADDR_WIDTH-1:0] raddr_b,
   output logic                  hazard_a,
   output logic                  hazard_b
);

   logic                  s2_valid;
   logic [ADDR_WIDTH-1:0] s2_addr;

   // Shift S1 into S2 every cycle; reset drops anything in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_valid <= 1'b0;
         s2_addr  <= '0;
      end else begin
         s2_valid <= s1_valid;
         s2_addr  <= s1_addr;
      end
   end

   // x0 is never written, so reading it is never a hazard.
   always_comb begin
      hazard_a = (raddr_a != '0) &&
                 ((s1_valid && (s1_addr == raddr_a)) || (s2_valid && (s2_addr == raddr_a)));
      hazard_b = (raddr_b != '0) &&
                 ((s1_valid && (s1_addr == raddr_b)) || (s2_valid && (s2_addr == raddr_b)));
   end

endmodule

// File: rtl/arcino_rf_wb_arbiter.sv
// Arbitrates EX and LSU writebacks onto the single RF write port through
// one registered issue stage, and raises read hazards for decode.
//
// Handshake: a source holds valid/waddr/wdata stable until ready; a transfer
// happens in any cycle where valid & ready. ready is combinational from the
// valids and the starve counter, and exactly one source is accepted in any
// cycle with at least one valid (the RF never back-pressures).
module arcino_rf_wb_arbiter
   import arcino_pkg::*;
#(
   parameter int RV32E       = 0,
   parameter int DataWidth   = 32,
   parameter int StarveLimit = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  ex_valid_i,
   input  logic [4:0]            ex_waddr_i,
   input  logic [DataWidth-1:0]  ex_wdata_i,
   output logic                  ex_ready_o,
   input  logic                  lsu_valid_i,
   input  logic [4:0]            lsu_waddr_i,
   input  logic [DataWidth-1:0]  lsu_wdata_i,
   output logic                  lsu_ready_o,
   output logic                  rf_we_o,
   output logic [4:0]            rf_waddr_o,
   output logic [DataWidth-1:0]  rf_wdata_o,
   input  logic [4:0]            raddr_a_i,
   input  logic [4:0]            raddr_b_i,
   output logic                  hazard_a_o,
   output logic                  hazard_b_o
);

   localparam int CntW = $clog2(StarveLimit + 1);
   localparam logic [CntW-1:0] CntMax = CntW'(StarveLimit);

   rf_wb_src_e            grant;
   logic [CntW-1:0]       starve_cnt;
   logic                  ex_prio;
   logic                  accept;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [DataWidth-1:0]  sel_data;

   assign ex_prio = (starve_cnt == CntMax);

   // LSU wins by default; EX wins once it has waited StarveLimit cycles.
   // Nothing is granted while reset is held.
   always_comb begin
      grant    = WB_SRC_NONE;
      sel_addr = rf_addr_mask(ex_waddr_i, RV32E != 0);
      sel_data = ex_wdata_i;
      if (!rst_i) begin
         if (ex_valid_i && (!lsu_valid_i || ex_prio)) begin
            grant = WB_SRC_EX;
         end else if (lsu_valid_i) begin
            grant    = WB_SRC_LSU;
            sel_addr = rf_addr_mask(lsu_waddr_i, RV32E != 0);
            sel_data = lsu_wdata_i;
         end
      end
   end

   assign ex_ready_o  = (grant == WB_SRC_EX);
   assign lsu_ready_o = (grant == WB_SRC_LSU);
   assign accept      = (grant != WB_SRC_NONE);

   // Count EX wait cycles, saturating at the limit; any EX grant clears it.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         starve_cnt <= '0;
      end else if (grant == WB_SRC_EX) begin
         starve_cnt <= '0;
      end else if (ex_valid_i && !ex_prio) begin
         starve_cnt <= starve_cnt + CntW'(1);
      end
   end

   // Issue register: an accepted x0 write is swallowed here (we stays low).
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rf_we_o    <= 1'b0;
         rf_waddr_o <= '0;
         rf_wdata_o <= '0;
      end else begin
         rf_we_o <= accept && (sel_addr != '0);
         if (accept) begin
            rf_waddr_o <= sel_addr;
            rf_wdata_o <= sel_data;
         end
      end
   end

   arcino_rf_inflight_trk u_trk (
      .clk      (clk_i),
      .rst      (rst_i),
      .s1_valid (rf_we_o),
      .s1_addr  (rf_waddr_o),
      .raddr_a  (rf_addr_mask(raddr_a_i, RV32E != 0)),
      .raddr_b  (rf_addr_mask(raddr_b_i, RV32E != 0)),
      .hazard_a (hazard_a_o),
      .hazard_b (hazard_b_o)
   );

endmodule

// File: tb/tb_arcino_rf_wb_arbiter.sv
// Directed bench for the RF writeback arbiter. A second instance built with
// RV32E=1 shares the same stimulus and is only checked in the RV32E scenario.
module tb_arcino_rf_wb_arbiter;

   logic        clk;
   logic        rst;
   logic        ex_valid, lsu_valid;
   logic [4:0]  ex_waddr, lsu_waddr, raddr_a, raddr_b;
   logic [31:0] ex_wdata, lsu_wdata;

   logic        ex_ready, lsu_ready, rf_we, hz_a, hz_b;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;

   logic        e_ex_ready, e_lsu_ready, e_rf_we, e_hz_a, e_hz_b;
   logic [4:0]  e_rf_waddr;
   logic [31:0] e_rf_wdata;

   int checks;
   int failures;

   arcino_rf_wb_arbiter #(.RV32E(0), .DataWidth(32), .StarveLimit(4)) u_dut (
      .clk_i(clk), .rst_i(rst),
      .ex_valid_i(ex_valid), .ex_waddr_i(ex_waddr), .ex_wdata_i(ex_wdata), .ex_ready_o(ex_ready),
      .lsu_valid_i(lsu_valid), .lsu_waddr_i(lsu_waddr), .lsu_wdata_i(lsu_wdata), .lsu_ready_o(lsu_ready),
      .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata),
      .raddr_a_i(raddr_a), .raddr_b_i(raddr_b), .hazard_a_o(hz_a), .hazard_b_o(hz_b)
   );

   arcino_rf_wb_arbiter #(.RV32E(1), .DataWidth(32), .StarveLimit(4)) u_dut_e (
      .clk_i(clk), .rst_i(rst),
      .ex_valid_i(ex_valid), .ex_waddr_i(ex_waddr), .ex_wdata_i(ex_wdata), .ex_ready_o(e_ex_ready),
      .lsu_valid_i(lsu_valid), .lsu_waddr_i(lsu_waddr), .lsu_wdata_i(lsu_wdata), .lsu_ready_o(e_lsu_ready),
      .rf_we_o(e_rf_we), .rf_waddr_o(e_rf_waddr), .rf_wdata_o(e_rf_wdata),
      .raddr_a_i(raddr_a), .raddr_b_i(raddr_b), .hazard_a_o(e_hz_a), .hazard_b_o(e_hz_b)
   );

   // Clock and reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      ex_valid = 0; ex_waddr = 0; ex_wdata = 0;
      lsu_valid = 0; lsu_waddr = 0; lsu_wdata = 0;
      raddr_a = 0; raddr_b = 0;
   endtask

   task automatic apply_reset;
      idle_inputs();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset;
      apply_reset();
      raddr_a = 5'd1; raddr_b = 5'd2;
      @(negedge clk);
      checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL reset_we got=%b exp=0", rf_we); end
      checks++; if (rf_waddr !== 5'd0) begin failures++; $display("FAIL reset_waddr got=%0d exp=0", rf_waddr); end
      checks++; if (rf_wdata !== 32'd0) begin failures++; $display("FAIL reset_wdata got=%h exp=0", rf_wdata); end
      checks++; if ({ex_ready, lsu_ready, hz_a, hz_b} !== 4'b0000)
         begin failures++; $display("FAIL reset_flags got=%b exp=0000", {ex_ready, lsu_ready, hz_a, hz_b}); end
   endtask

   task automatic test_reset_mid_write;
      apply_reset();
      lsu_valid = 1; lsu_waddr = 5'd7; lsu_wdata = 32'h1234_5678; raddr_a = 5'd7;
      @(negedge clk);
      checks++; if (lsu_ready !== 1'b1) begin failures++; $display("FAIL rmw_lsu_ready got=%b exp=1", lsu_ready); end
      step();
      checks++; if ({rf_we, hz_a} !== 2'b11) begin failures++; $display("FAIL rmw_issued got=%b exp=11", {rf_we, hz_a}); end
      lsu_valid = 0; ex_valid = 1; ex_waddr = 5'd9;
      rst = 1'b1;
      #1;
      checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL rmw_we_dropped got=%b exp=0", rf_we); end
      checks++; if (rf_waddr !== 5'd0) begin failures++; $display("FAIL rmw_waddr got=%0d exp=0", rf_waddr); end
      checks++; if ({hz_a, hz_b} !== 2'b00) begin failures++; $display("FAIL rmw_hazards got=%b exp=00", {hz_a, hz_b}); end
      checks++; if (ex_ready !== 1'b0) begin failures++; $display("FAIL rmw_ready_in_reset got=%b exp=0", ex_ready); end
      step();
      rst = 1'b0;
      idle_inputs();
   endtask

   task automatic test_single_ex;
      apply_reset();
      ex_valid = 1; ex_waddr = 5'd5; ex_wdata = 32'hDEAD_BEEF; raddr_a = 5'd5;
      @(negedge clk);
      checks++; if (ex_ready !== 1'b1) begin failures++; $display("FAIL ex_ready got=%b exp=1", ex_ready); end
      checks++; if (hz_a !== 1'b0) begin failures++; $display("FAIL ex_hz_n got=%b exp=0", hz_a); end
      step();
      ex_valid = 0;
      @(negedge clk);
      checks++; if (rf_we !== 1'b1) begin failures++; $display("FAIL ex_we got=%b exp=1", rf_we); end
      checks++; if (rf_waddr !== 5'd5) begin failures++; $display("FAIL ex_waddr got=%0d exp=5", rf_waddr); end
      checks++; if (rf_wdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL ex_wdata got=%h exp=deadbeef", rf_wdata); end
      checks++; if (hz_a !== 1'b1) begin failures++; $display("FAIL ex_hz_n1 got=%b exp=1", hz_a); end
      step();
      @(negedge clk);
      checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL ex_we_n2 got=%b exp=0", rf_we); end
      checks++; if (hz_a !== 1'b1) begin failures++; $display("FAIL ex_hz_n2 got=%b exp=1", hz_a); end
      step();
      @(negedge clk);
      checks++; if (hz_a !== 1'b0) begin failures++; $display("FAIL ex_hz_n3 got=%b exp=0", hz_a); end
      idle_inputs();
   endtask

   task automatic test_contention;
      apply_reset();
      lsu_valid = 1; lsu_waddr = 5'd3; lsu_wdata = 32'h11;
      ex_valid = 1; ex_waddr = 5'd4; ex_wdata = 32'h22;
      @(negedge clk);
      checks++; if ({lsu_ready, ex_ready} !== 2'b10) begin failures++; $display("FAIL cont_grant_n got=%b exp=10", {lsu_ready, ex_ready}); end
      step();
      lsu_valid = 0;
      @(negedge clk);
      checks++; if (ex_ready !== 1'b1) begin failures++; $display("FAIL cont_ex_ready_n1 got=%b exp=1", ex_ready); end
      checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd3, 32'h11})
         begin failures++; $display("FAIL cont_rf_n1 got=%b/%0d/%h exp=1/3/11", rf_we, rf_waddr, rf_wdata); end
      step();
      ex_valid = 0;
      @(negedge clk);
      checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd4, 32'h22})
         begin failures++; $display("FAIL cont_rf_n2 got=%b/%0d/%h exp=1/4/22", rf_we, rf_waddr, rf_wdata); end
      idle_inputs();
   endtask

   task automatic test_starvation;
      logic exp_ex;
      apply_reset();
      ex_valid = 1; ex_waddr = 5'd10; ex_wdata = 32'hE0;
      lsu_valid = 1; lsu_waddr = 5'd11; lsu_wdata = 32'hA0;
      for (int i = 0; i < 7; i++) begin
         exp_ex = (i == 4);
         @(negedge clk);
         checks++; if ({ex_ready, lsu_ready} !== {exp_ex, ~exp_ex})
            begin failures++; $display("FAIL starve_cyc%0d got=%b exp=%b", i, {ex_ready, lsu_ready}, {exp_ex, ~exp_ex}); end
         step();
         if (!exp_ex) lsu_wdata = lsu_wdata + 32'd1;
         if (i == 4) begin
            @(negedge clk);
            checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd10, 32'hE0})
               begin failures++; $display("FAIL starve_ex_issue got=%b/%0d/%h exp=1/10/e0", rf_we, rf_waddr, rf_wdata); end
         end
      end
      idle_inputs();
   endtask

   task automatic test_x0_drop;
      apply_reset();
      ex_valid = 1; ex_waddr = 5'd0; ex_wdata = 32'hFFFF_FFFF; raddr_a = 5'd0;
      @(negedge clk);
      checks++; if (ex_ready !== 1'b1) begin failures++; $display("FAIL x0_ready got=%b exp=1", ex_ready); end
      step();
      ex_valid = 0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++; if ({rf_we, hz_a} !== 2'b00) begin failures++; $display("FAIL x0_we_hz%0d got=%b exp=00", i, {rf_we, hz_a}); end
         step();
      end
      idle_inputs();
   endtask

   task automatic test_rv32e;
      apply_reset();
      lsu_valid = 1; lsu_waddr = 5'b10011; lsu_wdata = 32'h5A5A; raddr_b = 5'd3;
      @(negedge clk);
      checks++; if (e_lsu_ready !== 1'b1) begin failures++; $display("FAIL e_lsu_ready got=%b exp=1", e_lsu_ready); end
      step();
      lsu_valid = 0;
      @(negedge clk);
      checks++; if ({e_rf_we, e_rf_waddr} !== {1'b1, 5'd3}) begin failures++; $display("FAIL e_waddr got=%b/%0d exp=1/3", e_rf_we, e_rf_waddr); end
      checks++; if (e_hz_b !== 1'b1) begin failures++; $display("FAIL e_hz_b got=%b exp=1", e_hz_b); end
      checks++; if (rf_waddr !== 5'd19) begin failures++; $display("FAIL rv32i_waddr got=%0d exp=19", rf_waddr); end
      checks++; if (hz_b !== 1'b0) begin failures++; $display("FAIL rv32i_hz_b got=%b exp=0", hz_b); end
      idle_inputs();
   endtask

   task automatic test_back_to_back;
      apply_reset();
      lsu_valid = 1; lsu_waddr = 5'd9; lsu_wdata = 32'hAAAA_0001; raddr_a = 5'd9;
      step();
      lsu_wdata = 32'hBBBB_0002;
      @(negedge clk);
      checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd9, 32'hAAAA_0001})
         begin failures++; $display("FAIL b2b_first got=%b/%0d/%h exp=1/9/aaaa0001", rf_we, rf_waddr, rf_wdata); end
      step();
      lsu_valid = 0;
      @(negedge clk);
      checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd9, 32'hBBBB_0002})
         begin failures++; $display("FAIL b2b_second got=%b/%0d/%h exp=1/9/bbbb0002", rf_we, rf_waddr, rf_wdata); end
      step();
      step();
      @(negedge clk);
      checks++; if (hz_a !== 1'b0) begin failures++; $display("FAIL b2b_hz_clear got=%b exp=0", hz_a); end
      idle_inputs();
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      idle_inputs();
      test_reset();
      test_reset_mid_write();
      test_single_ex();
      test_contention();
      test_starvation();
      test_x0_drop();
      test_rv32e();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
